// File: rtl/rsa_job_sched.sv
// rtl/rsa_job_sched.sv - job/result FIFO scheduler around an external modexp unit
// Optional RUN-cycle watchdog (sets sticky err): define RSA_SCHED_TIMEOUT_EN.
module rsa_job_sched #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] job_data,
  input  logic             job_vld,
  output logic             job_rdy,
  output logic [WIDTH-1:0] res_data,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [WIDTH-1:0] rsa_m,
  output logic             rsa_rstb,
  output logic             rsa_en,
  input  logic             rsa_eoc,
  input  logic [WIDTH-1:0] rsa_c,
  output logic             busy,
  output logic             irq,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_STORE = 2'd3;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_params
    $error("rsa_job_sched: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] rsa_m_q, m_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             rsa_en_q, rsa_rstb_q, irq_q;
  logic             res_wr, job_pop;

  // Job FIFO
  logic [WIDTH-1:0] job_mem_q [DEPTH];
  logic [AW-1:0]    job_wr_q, job_rd_q;
  logic [AW:0]      job_cnt_q;
  logic             job_full, job_empty, job_push;

  assign job_full  = (job_cnt_q == CNT_FULL);
  assign job_empty = (job_cnt_q == '0);
  assign job_rdy   = !job_full;
  assign job_push  = job_vld && !job_full && !clear;

  always_ff @(posedge clk) begin
    if (job_push) begin
      job_mem_q[job_wr_q] <= job_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      job_wr_q  <= '0;
      job_rd_q  <= '0;
      job_cnt_q <= '0;
    end else if (clear) begin
      job_wr_q  <= '0;
      job_rd_q  <= '0;
      job_cnt_q <= '0;
    end else begin
      if (job_push) job_wr_q <= job_wr_q + PTR_ONE;
      if (job_pop)  job_rd_q <= job_rd_q + PTR_ONE;
      case ({job_push, job_pop})
        2'b10:   job_cnt_q <= job_cnt_q + CNT_ONE;
        2'b01:   job_cnt_q <= job_cnt_q - CNT_ONE;
        default: job_cnt_q <= job_cnt_q;
      endcase
    end
  end

  // Result FIFO; fullness is judged on the registered count, so a pop never frees room for a same-cycle write
  logic [WIDTH-1:0] res_mem_q [DEPTH];
  logic [AW-1:0]    res_wr_q, res_rd_q;
  logic [AW:0]      res_cnt_q;
  logic             res_full, res_empty, res_pop;

  assign res_full  = (res_cnt_q == CNT_FULL);
  assign res_empty = (res_cnt_q == '0);
  assign res_vld   = !res_empty;
  assign res_pop   = res_vld && res_rdy && !clear;
  assign res_data  = res_empty ? '0 : res_mem_q[res_rd_q];

  always_ff @(posedge clk) begin
    if (res_wr) begin
      res_mem_q[res_wr_q] <= c_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else if (clear) begin
      res_wr_q  <= '0;
      res_rd_q  <= '0;
      res_cnt_q <= '0;
    end else begin
      if (res_wr)  res_wr_q <= res_wr_q + PTR_ONE;
      if (res_pop) res_rd_q <= res_rd_q + PTR_ONE;
      case ({res_wr, res_pop})
        2'b10:   res_cnt_q <= res_cnt_q + CNT_ONE;
        2'b01:   res_cnt_q <= res_cnt_q - CNT_ONE;
        default: res_cnt_q <= res_cnt_q;
      endcase
    end
  end

`ifdef RSA_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMO_ONE  = TW'(1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    m_d     = rsa_m_q;
    c_d     = c_q;
    res_wr  = 1'b0;
    job_pop = 1'b0;
`ifdef RSA_SCHED_TIMEOUT_EN
    tmo_d   = tmo_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!job_empty) begin
          job_pop = 1'b1;
          m_d     = job_mem_q[job_rd_q];
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
`ifdef RSA_SCHED_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      ST_RUN: begin
        if (rsa_eoc) begin
          c_d     = rsa_c;
          state_d = ST_STORE;
        end
`ifdef RSA_SCHED_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_d   = tmo_q + TMO_ONE;
        end
`endif
      end
      ST_STORE: begin
        if (!res_full) begin
          res_wr  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (clear) begin
      state_d = ST_IDLE;
      m_d     = rsa_m_q;
      res_wr  = 1'b0;
      job_pop = 1'b0;
`ifdef RSA_SCHED_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end
  end

  // Unit controls are registered from the next state so they line up with state_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rsa_m_q    <= '0;
      c_q        <= '0;
      rsa_en_q   <= 1'b0;
      rsa_rstb_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsa_m_q    <= m_d;
      c_q        <= c_d;
      rsa_en_q   <= (state_d == ST_RUN);
      rsa_rstb_q <= (state_d != ST_LOAD);
      irq_q      <= res_wr;
    end
  end

`ifdef RSA_SCHED_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign rsa_m    = rsa_m_q;
  assign rsa_en   = rsa_en_q;
  assign rsa_rstb = rsa_rstb_q;
  assign irq      = irq_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rsa_job_sched.sv
// tb/tb_rsa_job_sched.sv - directed and randomized checks of rsa_job_sched against a queue model
module tb_rsa_job_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] job_data = 8'h00;
  logic       job_vld = 1'b0;
  logic       res_rdy = 1'b0;
  logic       job_rdy, res_vld, rsa_rstb, rsa_en, rsa_eoc, busy, irq, err;
  logic [7:0] res_data, rsa_m, rsa_c;

  rsa_job_sched #(.WIDTH(8), .DEPTH(4), .TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .job_data(job_data), .job_vld(job_vld), .job_rdy(job_rdy),
    .res_data(res_data), .res_vld(res_vld), .res_rdy(res_rdy),
    .rsa_m(rsa_m), .rsa_rstb(rsa_rstb), .rsa_en(rsa_en),
    .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
    .busy(busy), .irq(irq), .err(err)
  );

  always #5 clk = ~clk;

  // Modexp stand-in: C = 7*M + 0x6B, eoc on its lat-th enabled cycle (lat 0 = never)
  function automatic logic [7:0] unit_f(input logic [7:0] m);
    return 8'(m * 8'd7 + 8'h6B);
  endfunction

  int lat_lo = 10, lat_hi = 10, cur_lat = 10, ucnt = 0;
  always @(posedge clk) begin
    if (!rsa_rstb) begin
      ucnt    <= 0;
      cur_lat <= int'($urandom_range(lat_hi, lat_lo));
    end else if (rsa_en) begin
      ucnt <= ucnt + 1;
    end
  end
  assign rsa_eoc = rsa_en && (cur_lat != 0) && (ucnt == cur_lat - 1);
  assign rsa_c   = unit_f(rsa_m);

  int vectors = 0, miscompares = 0, irq_cnt = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: model the handshakes the DUT is about to see, then advance
  task automatic cycle();
    logic push, pop;
    push = job_vld && job_rdy && !clear && rst_n;
    pop  = res_vld && res_rdy && !clear && rst_n;
    if (pop) begin
      chk("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("res_data_order", res_data, exp_q.pop_front());
    end
    if (push) exp_q.push_back(unit_f(job_data));
    if (clear) exp_q.delete();
    @(posedge clk);
    #1;
    if (irq === 1'b1) irq_cnt++;
  endtask

  task automatic push_n(input int n, input string tag);
    int acc = 0, t = 0;
    job_vld = 1'b1;
    while (acc < n && t < 40) begin
      job_data = 8'($urandom);
      if (job_rdy) acc++;
      cycle();
      t++;
    end
    job_vld = 1'b0;
    chk(tag, acc, n);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    res_rdy = 1'b1;
    while (exp_q.size() > 0 && t < 600) begin
      cycle();
      t++;
    end
    res_rdy = 1'b0;
    chk(tag, exp_q.size(), 0);
    chk({tag, "_vld"}, res_vld, 0);
  endtask

  initial begin
    int t, en_cnt, rstb_low, i0, pushes;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rstb", rsa_rstb, 0);
    chk("rst_en", rsa_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_err", err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_res_vld", res_vld, 0);
    chk("rst_job_rdy", job_rdy, 1);
    chk("rst_rsa_m", rsa_m, 0);
    rst_n = 1'b1;
    cycle();
    chk("rstb_after_release", rsa_rstb, 1);

    // Single job, M=0x05, 10 RUN cycles
    job_data = 8'h05;
    job_vld  = 1'b1;
    cycle();
    job_vld = 1'b0;
    t = 0; en_cnt = 0; rstb_low = 0; i0 = irq_cnt;
    while (res_vld !== 1'b1 && t < 40) begin
      cycle();
      t++;
      if (rsa_en === 1'b1) en_cnt++;
      if (rsa_rstb === 1'b0) rstb_low++;
      if (t == 1) chk("load_busy", busy, 1);
      if (t == 2) chk("run_rsa_m", rsa_m, 8'h05);
    end
    chk("latency", t, 13);
    chk("en_cycles", en_cnt, 10);
    chk("rstb_low_cycles", rstb_low, 1);
    chk("res_data_8e", res_data, 8'h8E);
    chk("irq_pulses", irq_cnt - i0, 1);
    chk("idle_after_store", busy, 0);
    res_rdy = 1'b1;
    cycle();
    res_rdy = 1'b0;
    chk("single_popped", res_vld, 0);

    // Five back-to-back jobs into a slow unit
    lat_lo = 30; lat_hi = 30;
    pushes = 0; t = 0;
    job_vld = 1'b1;
    while (pushes < 5 && t < 20) begin
      job_data = 8'($urandom);
      if (job_rdy) pushes++;
      cycle();
      t++;
    end
    job_vld = 1'b0;
    chk("five_accept_cycles", t, 5);
    chk("job_rdy_full", job_rdy, 0);
    drain("five_drain");

    // Result FIFO back-pressure
    lat_lo = 3; lat_hi = 3;
    i0 = irq_cnt;
    push_n(5, "bp_push");
    repeat (80) cycle();
    chk("bp_res_vld", res_vld, 1);
    chk("bp_busy_store", busy, 1);
    chk("bp_en_low", rsa_en, 0);
    chk("bp_job_rdy", job_rdy, 1);
    chk("bp_irq_fill", irq_cnt - i0, 4);
    res_rdy = 1'b1;
    cycle();
    res_rdy = 1'b0;
    i0 = irq_cnt;
    repeat (4) cycle();
    chk("bp_release_one", irq_cnt - i0, 1);
    chk("bp_release_idle", busy, 0);
    drain("bp_drain");

    // clear during RUN with 3 queued
    lat_lo = 50; lat_hi = 50;
    push_n(4, "clr_push");
    chk("clr_pre_busy", busy, 1);
    chk("clr_pre_en", rsa_en, 1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("clr_job_rdy", job_rdy, 1);
    chk("clr_res_vld", res_vld, 0);
    chk("clr_busy", busy, 0);
    chk("clr_en", rsa_en, 0);
    chk("clr_irq", irq, 0);
    i0 = irq_cnt;
    repeat (60) cycle();
    chk("clr_no_irq", irq_cnt - i0, 0);
    chk("clr_still_empty", res_vld, 0);

`ifdef RSA_SCHED_TIMEOUT_EN
    // Watchdog: unit never finishes
    lat_lo = 0; lat_hi = 0;
    push_n(1, "tmo_push");
    t = 0; en_cnt = 0; i0 = irq_cnt;
    while (err !== 1'b1 && t < 60) begin
      cycle();
      t++;
      if (rsa_en === 1'b1) en_cnt++;
    end
    chk("tmo_err", err, 1);
    chk("tmo_run_cycles", en_cnt, 20);
    chk("tmo_no_result", res_vld, 0);
    chk("tmo_no_irq", irq_cnt - i0, 0);
    exp_q.delete();
    lat_lo = 4; lat_hi = 4;
    push_n(1, "tmo_next_push");
    drain("tmo_next");
    chk("tmo_err_sticky", err, 1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("tmo_err_cleared", err, 0);
`else
    // No watchdog: RUN waits indefinitely, err stays 0
    lat_lo = 0; lat_hi = 0;
    push_n(1, "hang_push");
    repeat (60) cycle();
    chk("hang_busy", busy, 1);
    chk("hang_en", rsa_en, 1);
    chk("hang_err", err, 0);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("hang_cleared", busy, 0);
`endif

    // Asynchronous reset mid-RUN
    lat_lo = 20; lat_hi = 20;
    push_n(1, "ar_push");
    repeat (6) cycle();
    rst_n = 1'b0;
    #1;
    chk("ar_rstb", rsa_rstb, 0);
    chk("ar_en", rsa_en, 0);
    chk("ar_busy", busy, 0);
    chk("ar_irq", irq, 0);
    chk("ar_err", err, 0);
    chk("ar_res_data", res_data, 0);
    chk("ar_rsa_m", rsa_m, 0);
    chk("ar_job_rdy", job_rdy, 1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle();
    chk("ar_rstb_release", rsa_rstb, 1);
    lat_lo = 5; lat_hi = 5;
    push_n(1, "ar_fresh_push");
    drain("ar_fresh");

    // Randomized traffic
    lat_lo = 1; lat_hi = 6;
    pushes = 0; i0 = irq_cnt;
    for (int i = 0; i < 300; i++) begin
      job_vld  = ($urandom_range(1, 0) == 1);
      job_data = 8'($urandom);
      res_rdy  = ($urandom_range(9, 0) < 6);
      if (job_vld && job_rdy) pushes++;
      cycle();
    end
    job_vld = 1'b0;
    drain("rand_drain");
    chk("rand_irq_total", irq_cnt - i0, pushes);
    chk("rand_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
